// File: rtl/token_repeat_arbiter_pkg.sv
// token_arb_pkg: shared defaults and sizing helpers for token_repeat_arbiter.
//   N_LANES_DEF     - default number of serial request lanes
//   REPEAT_DEF      - default output pulses owed per input token
//   MAX_PENDING_DEF - default per-lane owed-pulse ceiling before overflow
//   STATS_W         - width of the optional emitted-pulse counter
//   cnt_width()     - pending counter width for a given ceiling/repeat pair
package token_arb_pkg;

  localparam int unsigned N_LANES_DEF     = 4;
  localparam int unsigned REPEAT_DEF      = 2;
  localparam int unsigned MAX_PENDING_DEF = 200;
  localparam int unsigned STATS_W         = 16;

  // Wide enough to hold MAX_PENDING + REPEAT, the largest next-count candidate.
  function automatic int unsigned cnt_width(input int unsigned max_pending,
                                            input int unsigned repeat_n);
    return $clog2(max_pending + repeat_n + 1);
  endfunction

endpackage

// File: rtl/token_repeat_arbiter_lane_counter.sv
// token_lane_counter: one lane's owed-pulse counter with sticky overflow.
//   clk, rst     - clock, asynchronous active-high reset
//   tok_i        - one token on this lane this cycle (adds REPEAT owed pulses)
//   grant_i      - arbiter granted this lane this cycle (removes one owed pulse)
//   count_o      - registered pending count
//   overflow_o   - registered sticky overflow flag; lane is dead until reset
module token_lane_counter
  import token_arb_pkg::*;
#(
  parameter int unsigned REPEAT      = REPEAT_DEF,
  parameter int unsigned MAX_PENDING = MAX_PENDING_DEF,
  parameter int unsigned CW          = cnt_width(MAX_PENDING_DEF, REPEAT_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tok_i,
  input  logic          grant_i,
  output logic [CW-1:0] count_o,
  output logic          overflow_o
);

  localparam int unsigned SW = CW + 1;

  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [SW-1:0] sum;

  // Next count: increment and decrement land on the same edge.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    sum     = {1'b0, count_q}
            + ((tok_i && !ovf_q) ? SW'(REPEAT) : SW'(0))
            - (grant_i ? SW'(1) : SW'(0));
    if (ovf_q) begin
      count_d = '0;
    end else if (sum > SW'(MAX_PENDING)) begin
      ovf_d   = 1'b1;
      count_d = '0;
    end else begin
      count_d = sum[CW-1:0];
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/token_repeat_arbiter.sv
// token_repeat_arbiter: collects serial tokens on N_LANES lanes, owes REPEAT
// output pulses per token, and emits them one per cycle on a shared serial
// output using round-robin arbitration across lanes.
//   clk, rst    - clock, asynchronous active-high reset
//   a           - per-lane token strobes
//   b           - registered pulse output
//   b_id        - registered lane index owning the pulse on b (0 when idle)
//   overflow    - registered sticky per-lane overflow flags
//   busy        - combinational: some live lane still owes pulses
//   pulse_count - saturating count of emitted pulses; present only when
//                 TOKEN_REPEAT_ARBITER_STATS_EN is defined
module token_repeat_arbiter
  import token_arb_pkg::*;
#(
  parameter int unsigned N_LANES     = N_LANES_DEF,
  parameter int unsigned REPEAT      = REPEAT_DEF,
  parameter int unsigned MAX_PENDING = MAX_PENDING_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_LANES-1:0]         a,
  output logic                       b,
  output logic [$clog2(N_LANES)-1:0] b_id,
  output logic [N_LANES-1:0]         overflow,
  output logic                       busy
`ifdef TOKEN_REPEAT_ARBITER_STATS_EN
  ,
  output logic [STATS_W-1:0]         pulse_count
`endif
);

  localparam int unsigned IDW = $clog2(N_LANES);
  localparam int unsigned CW  = cnt_width(MAX_PENDING, REPEAT);

  logic [CW-1:0]      count [N_LANES];
  logic [N_LANES-1:0] elig;
  logic [N_LANES-1:0] gnt_vec;
  logic               gnt_valid;
  logic [IDW-1:0]     gnt_idx;

  logic               b_q, b_d;
  logic [IDW-1:0]     b_id_q, b_id_d;
  logic [IDW-1:0]     last_q, last_d;

  // Per-lane counters.
  for (genvar i = 0; i < int'(N_LANES); i++) begin : g_lane
    token_lane_counter #(
      .REPEAT      (REPEAT),
      .MAX_PENDING (MAX_PENDING),
      .CW          (CW)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .tok_i      (a[i]),
      .grant_i    (gnt_vec[i]),
      .count_o    (count[i]),
      .overflow_o (overflow[i])
    );
  end

  // Eligibility from pre-edge counts; overflowed lanes never compete.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      elig[i] = (count[i] != '0) && !overflow[i];
    end
  end

  assign busy = |elig;

  // Round-robin pick starting one past the last granted lane.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt_vec   = '0;
    for (int unsigned off = 1; off <= N_LANES; off++) begin
      cand = (32'(last_q) + off) % N_LANES;
      if (!gnt_valid && elig[IDW'(cand)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDW'(cand);
      end
    end
    for (int unsigned i = 0; i < N_LANES; i++) begin
      gnt_vec[i] = gnt_valid && (gnt_idx == IDW'(i));
    end
  end

  // Output and pointer next-state.
  always_comb begin
    b_d    = gnt_valid;
    b_id_d = gnt_valid ? gnt_idx : '0;
    last_d = gnt_valid ? gnt_idx : last_q;
  end

  // Reset pointer at the top lane so lane 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q    <= 1'b0;
      b_id_q <= '0;
      last_q <= IDW'(N_LANES - 1);
    end else begin
      b_q    <= b_d;
      b_id_q <= b_id_d;
      last_q <= last_d;
    end
  end

  assign b    = b_q;
  assign b_id = b_id_q;

`ifdef TOKEN_REPEAT_ARBITER_STATS_EN
  logic [STATS_W-1:0] pulse_q, pulse_d;

  // Saturating emitted-pulse counter, advancing with each grant.
  always_comb begin
    pulse_d = pulse_q;
    if (gnt_valid && (pulse_q != '1)) begin
      pulse_d = pulse_q + STATS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  assign pulse_count = pulse_q;
`endif

endmodule

// File: tb/tb_token_repeat_arbiter.sv
// Directed bench for token_repeat_arbiter at default parameters
// (N_LANES=4, REPEAT=2, MAX_PENDING=200).
module tb_token_repeat_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic       b;
  logic [1:0] b_id;
  logic [3:0] overflow;
  logic       busy;
`ifdef TOKEN_REPEAT_ARBITER_STATS_EN
  logic [15:0] pulse_count;
`endif

  int checks = 0;
  int errors = 0;

  token_repeat_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .b_id     (b_id),
    .overflow (overflow),
    .busy     (busy)
`ifdef TOKEN_REPEAT_ARBITER_STATS_EN
    ,
    .pulse_count (pulse_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a   = 4'b0000;
    tick();
    tick();
    chk("rst_b", 32'(b), 32'd0);
    chk("rst_bid", 32'(b_id), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Single token on lane 0: two back-to-back pulses then idle.
    a = 4'b0001;
    tick();
    a = 4'b0000;
    chk("single_e0_b", 32'(b), 32'd0);
    chk("single_e0_busy", 32'(busy), 32'd1);
    tick();
    chk("single_e1_b", 32'(b), 32'd1);
    chk("single_e1_bid", 32'(b_id), 32'd0);
    tick();
    chk("single_e2_b", 32'(b), 32'd1);
    chk("single_e2_bid", 32'(b_id), 32'd0);
    chk("single_e2_busy", 32'(busy), 32'd0);
    tick();
    chk("single_e3_b", 32'(b), 32'd0);

    // All four lanes at once: round-robin 0,1,2,3 twice.
    pulse_rst();
    a = 4'b1111;
    tick();
    a = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rr_b_%0d", k), 32'(b), 32'd1);
      chk($sformatf("rr_bid_%0d", k), 32'(b_id), 32'(k % 4));
      chk($sformatf("rr_busy_%0d", k), 32'(busy), (k == 7) ? 32'd0 : 32'd1);
    end
    tick();
    chk("rr_end_b", 32'(b), 32'd0);
    chk("rr_end_bid", 32'(b_id), 32'd0);

    // Lanes 0 and 2: pointer must skip idle lanes 1 and 3.
    pulse_rst();
    a = 4'b0101;
    tick();
    a = 4'b0000;
    tick();
    chk("skip_bid_0", 32'(b_id), 32'd0);
    tick();
    chk("skip_bid_1", 32'(b_id), 32'd2);
    tick();
    chk("skip_bid_2", 32'(b_id), 32'd0);
    tick();
    chk("skip_bid_3", 32'(b_id), 32'd2);
    chk("skip_busy", 32'(busy), 32'd0);
    tick();
    chk("skip_end_b", 32'(b), 32'd0);

    // Reset mid-burst: three tokens on lane 0, reset discards owed pulses.
    a = 4'b0001;
    tick();
    tick();
    tick();
    a = 4'b0000;
    chk("mid_pre_b", 32'(b), 32'd1);
    chk("mid_pre_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_b", 32'(b), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mid_after_b_%0d", k), 32'(b), 32'd0);
    end

    // Saturation: lane 2 held; count is e+1 after edge e, 201 at edge 200.
    pulse_rst();
    a = 4'b0100;
    tick();
    chk("sat_e1_b", 32'(b), 32'd0);
    for (int e = 2; e <= 199; e++) begin
      tick();
      chk($sformatf("sat_b_%0d", e), 32'(b), 32'd1);
      chk($sformatf("sat_bid_%0d", e), 32'(b_id), 32'd2);
    end
    chk("sat_e199_ovf", 32'(overflow), 32'd0);
    tick();
    chk("sat_e200_ovf", 32'(overflow), 32'b0100);
    chk("sat_e200_b", 32'(b), 32'd1);
    chk("sat_e200_busy", 32'(busy), 32'd0);
    tick();
    chk("sat_e201_b", 32'(b), 32'd0);
    chk("sat_e201_ovf", 32'(overflow), 32'b0100);

    // Sticky isolation: lane 1 still works while lane 2 stays dead.
    a = 4'b0010;
    tick();
    a = 4'b0100;
    tick();
    chk("iso_b_0", 32'(b), 32'd1);
    chk("iso_bid_0", 32'(b_id), 32'd1);
    tick();
    chk("iso_b_1", 32'(b), 32'd1);
    chk("iso_bid_1", 32'(b_id), 32'd1);
    tick();
    chk("iso_end_b", 32'(b), 32'd0);
    chk("iso_ovf", 32'(overflow), 32'b0100);
    a = 4'b0000;
    pulse_rst();
    chk("iso_rst_ovf", 32'(overflow), 32'd0);

`ifdef TOKEN_REPEAT_ARBITER_STATS_EN
    // Ten tokens total must produce twenty pulses.
    pulse_rst();
    a = 4'b1111;
    tick();
    tick();
    a = 4'b0011;
    tick();
    a = 4'b0000;
    begin
      int n;
      n = 0;
      while (busy && n < 100) begin
        tick();
        n++;
      end
      chk("stats_drain", 32'(busy), 32'd0);
    end
    chk("stats_count", 32'(pulse_count), 32'd20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
